// File: rtl/emboss_pkg.sv
// rtl/emboss_pkg.sv - shared defaults and counter-width helper for the emboss line buffer
package emboss_pkg;

    localparam int EMB_PIX_W      = 8;
    localparam int EMB_IMG_WIDTH  = 512;
    localparam int EMB_IMG_HEIGHT = 512;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port read-first line RAM with synchronous read
module line_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // Read data only advances on enable so it holds while the pipeline stalls.
    always_comb begin
        rd_data_d = rd_data_q;
        if (en) begin
            rd_data_d = mem[addr];
        end
    end

    // Read-first: the old word is captured in the same cycle it is overwritten.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/emboss_line_buffer.sv
// rtl/emboss_line_buffer.sv - three-row column feeder for the emboss filter; EMBOSS_ZERO_PAD_EN emits zero-padded rows 0/1
module emboss_line_buffer
    import emboss_pkg::*;
#(
    parameter int IMG_WIDTH  = EMB_IMG_WIDTH,
    parameter int IMG_HEIGHT = EMB_IMG_HEIGHT,
    parameter int PIX_W      = EMB_PIX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PIX_W-1:0] i_pixel,
    input  logic             i_pixel_valid,
    output logic             o_pixel_ack,
    output logic [PIX_W-1:0] o_pixel_1,
    output logic [PIX_W-1:0] o_pixel_2,
    output logic [PIX_W-1:0] o_pixel_3,
    output logic             o_pixel_valid,
    input  logic             i_pixel_ack
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_d, col_q;
    logic [ROW_W-1:0] row_d, row_q;
    logic             sel_d, sel_q;
    logic             rd_sel_d, rd_sel_q;
    logic             pad1_d, pad1_q;
    logic             pad2_d, pad2_q;
    logic [PIX_W-1:0] pix3_d, pix3_q;
    logic             valid_d, valid_q;

    logic             in_xfer;
    logic             emit;
    logic [PIX_W-1:0] a_rd, b_rd;

    assign o_pixel_ack = ~valid_q | i_pixel_ack;
    assign in_xfer     = i_pixel_valid & o_pixel_ack;

`ifdef EMBOSS_ZERO_PAD_EN
    assign emit = in_xfer;
`else
    assign emit = in_xfer & (row_q >= ROW_W'(2));
`endif

    // sel=0 makes ram_a the older row; the incoming pixel always replaces the older row.
    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) ram_a (
        .clk   (i_clk),
        .en    (in_xfer),
        .we    (in_xfer & ~sel_q),
        .addr  (col_q),
        .wdata (i_pixel),
        .rdata (a_rd)
    );

    line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) ram_b (
        .clk   (i_clk),
        .en    (in_xfer),
        .we    (in_xfer & sel_q),
        .addr  (col_q),
        .wdata (i_pixel),
        .rdata (b_rd)
    );

    // Raster position, RAM role swap, output column capture and valid tracking.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        sel_d    = sel_q;
        rd_sel_d = rd_sel_q;
        pad1_d   = pad1_q;
        pad2_d   = pad2_q;
        pix3_d   = pix3_q;
        valid_d  = emit | (valid_q & ~i_pixel_ack);
        if (in_xfer) begin
            // sel may toggle on this transfer, so remember the role used for this read.
            rd_sel_d = sel_q;
            pad1_d   = (row_q < ROW_W'(2));
            pad2_d   = (row_q == '0);
            pix3_d   = i_pixel;
            if (col_q == COL_MAX) begin
                col_d = '0;
                sel_d = ~sel_q;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Pad flags reset high so the upper rows read as zero without clearing the RAMs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q    <= '0;
            row_q    <= '0;
            sel_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            pad1_q   <= 1'b1;
            pad2_q   <= 1'b1;
            pix3_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            sel_q    <= sel_d;
            rd_sel_q <= rd_sel_d;
            pad1_q   <= pad1_d;
            pad2_q   <= pad2_d;
            pix3_q   <= pix3_d;
            valid_q  <= valid_d;
        end
    end

    assign o_pixel_1     = pad1_q ? '0 : (rd_sel_q ? b_rd : a_rd);
    assign o_pixel_2     = pad2_q ? '0 : (rd_sel_q ? a_rd : b_rd);
    assign o_pixel_3     = pix3_q;
    assign o_pixel_valid = valid_q;

endmodule

// File: tb/tb_emboss_line_buffer.sv
// tb/tb_emboss_line_buffer.sv - randomized self-checking bench for emboss_line_buffer
module tb_emboss_line_buffer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
`ifdef EMBOSS_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [PW-1:0] i_pixel;
    logic          i_pixel_valid;
    logic          o_pixel_ack;
    logic [PW-1:0] o_pixel_1, o_pixel_2, o_pixel_3;
    logic          o_pixel_valid;
    logic          i_pixel_ack;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] obs_q[$];
    int stall_bad;
    int stall_cycles;
    int timeouts;

    emboss_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pixel       (i_pixel),
        .i_pixel_valid (i_pixel_valid),
        .o_pixel_ack   (o_pixel_ack),
        .o_pixel_1     (o_pixel_1),
        .o_pixel_2     (o_pixel_2),
        .o_pixel_3     (o_pixel_3),
        .o_pixel_valid (o_pixel_valid),
        .i_pixel_ack   (i_pixel_ack)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [PW-1:0] pix_of(input int k);
        int r = (k / W) % H;
        int c = k % W;
        return PW'(16 * r + c);
    endfunction

    function automatic bit emits(input int k);
        return PAD || (((k / W) % H) >= 2);
    endfunction

    // Column for stream pixel k: rows r-2, r-1, r of the same column, zero above the frame.
    function automatic logic [23:0] exp_of(input int k);
        int r = (k / W) % H;
        int c = k % W;
        logic [7:0] top, mid, cur;
        cur = 8'(16 * r + c);
        mid = (r >= 1) ? 8'(16 * (r - 1) + c) : 8'h00;
        top = (r >= 2) ? 8'(16 * (r - 2) + c) : 8'h00;
        return {top, mid, cur};
    endfunction

    function automatic logic [23:0] outs();
        return {o_pixel_1, o_pixel_2, o_pixel_3};
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        i_pixel_valid = 1'b0;
        i_pixel_ack = 1'b0;
        i_pixel = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    // Drives n_pix raster pixels from a fresh frame with random handshakes, logging accepted outputs.
    task automatic drive_stream(input int n_pix, input int v_pct, input int a_pct,
                                input int stall_k, input int stall_len);
        int k = 0;
        int cyc = 0;
        int stall_rem = 0;
        bit stall_done = 0;
        logic [23:0] snap = '0;
        obs_q.delete();
        stall_bad = 0;
        stall_cycles = 0;
        while ((k < n_pix || o_pixel_valid) && cyc < 4000) begin
            if (!stall_done && stall_len > 0 && k == stall_k && o_pixel_valid) begin
                stall_done = 1;
                stall_rem = stall_len;
                snap = outs();
            end
            i_pixel = pix_of(k);
            if (stall_rem > 0) begin
                i_pixel_valid = 1'b1;
                i_pixel_ack = 1'b0;
            end else begin
                i_pixel_valid = (k < n_pix) && (($urandom % 100) < v_pct);
                i_pixel_ack = (($urandom % 100) < a_pct);
            end
            @(negedge i_clk);
            if (stall_rem > 0) begin
                stall_cycles++;
                if (o_pixel_ack !== 1'b0 || o_pixel_valid !== 1'b1 || outs() !== snap) stall_bad++;
                stall_rem--;
            end
            if (o_pixel_valid && i_pixel_ack) obs_q.push_back(outs());
            if (i_pixel_valid && o_pixel_ack) k++;
            @(posedge i_clk);
            #1;
            cyc++;
        end
        if (cyc >= 4000) timeouts++;
        i_pixel_valid = 1'b0;
        i_pixel_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge i_clk);
        n_checks++;
        if (o_pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", o_pixel_valid);
        end
        n_checks++;
        if (outs() !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 000000", outs());
        end
        n_checks++;
        if (o_pixel_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ack: got %b want 1", o_pixel_ack);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_stream();
        logic [23:0] exp_q[$];
        do_reset();
        timeouts = 0;
        drive_stream(W * H, 100, 100, -1, 0);
        for (int k = 0; k < W * H; k++) if (emits(k)) exp_q.push_back(exp_of(k));
        n_checks++;
        if (obs_q.size() != exp_q.size() || timeouts != 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d outputs (timeouts %0d) want %0d", obs_q.size(), timeouts, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
`ifdef EMBOSS_ZERO_PAD_EN
        if (obs_q.size() == 16) begin
            n_checks++;
            if (obs_q[0] !== 24'h000000 || obs_q[4] !== 24'h000010 || obs_q[8] !== 24'h001020) begin
                n_fail++;
                $display("FAIL stream_pad_points: got %h/%h/%h want 000000/000010/001020", obs_q[0], obs_q[4], obs_q[8]);
            end
        end
`else
        if (obs_q.size() == 8) begin
            n_checks++;
            if (obs_q[0] !== 24'h001020 || obs_q[7] !== 24'h132333) begin
                n_fail++;
                $display("FAIL stream_ends: got %h/%h want 001020/132333", obs_q[0], obs_q[7]);
            end
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [23:0] exp_q[$];
        do_reset();
        timeouts = 0;
        drive_stream(W * H, 100, 100, 10, 5);
        for (int k = 0; k < W * H; k++) if (emits(k)) exp_q.push_back(exp_of(k));
        n_checks++;
        if (stall_cycles != 5 || stall_bad != 0) begin
            n_fail++;
            $display("FAIL stall_freeze: got %0d stall cycles %0d bad want 5 and 0", stall_cycles, stall_bad);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size() || timeouts != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_q[$];
        int idx = 0;
        do_reset();
        timeouts = 0;
        drive_stream(3 * W * H, 70, 60, -1, 0);
        for (int k = 0; k < 3 * W * H; k++) if (emits(k)) exp_q.push_back(exp_of(k));
        for (int k = 0; k < 2 * W * H + 2 * W; k++) if (emits(k)) idx++;
        n_checks++;
        if (obs_q.size() != exp_q.size() || timeouts != 0) begin
            n_fail++;
            $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (idx >= obs_q.size() || obs_q[idx] !== 24'h001020) begin
            n_fail++;
            $display("FAIL random_frame2: got %h want 001020", (idx < obs_q.size()) ? obs_q[idx] : 24'hxxxxxx);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] exp_q[$];
        do_reset();
        i_pixel_ack = 1'b1;
        for (int k = 0; k < 2 * W + 2; k++) begin
            i_pixel_valid = 1'b1;
            i_pixel = pix_of(k);
            @(posedge i_clk);
            #1;
        end
        i_pixel_valid = 1'b0;
        i_pixel_ack = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_pixel_valid !== 1'b1 || outs() !== exp_of(2 * W + 1)) begin
            n_fail++;
            $display("FAIL midrst_pre: got %b/%h want 1/%h", o_pixel_valid, outs(), exp_of(2 * W + 1));
        end
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (o_pixel_valid !== 1'b0 || outs() !== 24'h0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b/%h want 0/000000", o_pixel_valid, outs());
        end
        @(posedge i_clk);
        #1;
        timeouts = 0;
        drive_stream(W * H, 100, 100, -1, 0);
        for (int k = 0; k < W * H; k++) if (emits(k)) exp_q.push_back(exp_of(k));
        n_checks++;
        if (obs_q.size() != exp_q.size() || timeouts != 0) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midrst_out[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_pixel_ack = 1'b1;
        for (int j = 0; j <= W * H; j++) begin
            i_pixel_valid = (j < W * H);
            i_pixel = pix_of(j);
            @(negedge i_clk);
            if (j >= 1 && emits(j - 1)) begin
                n_checks++;
                if (o_pixel_valid !== 1'b1 || o_pixel_ack !== 1'b1 || outs() !== exp_of(j - 1)) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got v=%b a=%b %h want v=1 a=1 %h",
                             j - 1, o_pixel_valid, o_pixel_ack, outs(), exp_of(j - 1));
                end
            end
            @(posedge i_clk);
            #1;
        end
        i_pixel_valid = 1'b0;
        i_pixel_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        timeouts = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
